// File: rtl/tsu_rx_ptp_capture_pkg.sv
// Shared XGMII/PTP constants, record layout and lane-scan helper for the
// receive-side PTP timestamp capture path.
package tsu_rx_ptp_capture_pkg;

  localparam logic [7:0]  XGMII_START = 8'hFB;
  localparam logic [7:0]  XGMII_TERM  = 8'hFD;
  localparam logic [7:0]  XGMII_ERR   = 8'hFE;

  localparam logic [15:0] PTP_ETYPE   = 16'h88F7;
  localparam logic [3:0]  PTP_VERSION = 4'd2;

  // Aligned-word indices carrying EtherType/PTP common header and sequenceId.
  localparam logic [2:0]  ETYPE_W = 3'd2;
  localparam logic [2:0]  SEQ_W   = 3'd6;

  localparam int REC_W = 100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_WAIT_END
  } cap_state_t;

  typedef struct packed {
    logic [47:0] sec;
    logic [31:0] ns;
    logic [3:0]  msg_type;
    logic [15:0] seq_id;
  } ts_rec_t;

  function automatic logic lane_has(input logic [63:0] d, input logic [7:0] c,
                                    input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (c[i] && (d[8*i +: 8] == code)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/tsu_rx_ptp_capture_if.sv
// Timestamp record read port between the capture stage and the timestamp unit.
interface tsu_rx_ptp_capture_if;

  logic        ts_rd_i;
  logic        ts_valid_o;
  logic [47:0] ts_sec_o;
  logic [31:0] ts_ns_o;
  logic [3:0]  ts_msg_type_o;
  logic [15:0] ts_seq_id_o;
  logic        ts_push_o;
  logic [7:0]  ts_ovf_cnt_o;

  modport master (
    input  ts_rd_i,
    output ts_valid_o, ts_sec_o, ts_ns_o, ts_msg_type_o, ts_seq_id_o,
           ts_push_o, ts_ovf_cnt_o
  );

  modport slave (
    output ts_rd_i,
    input  ts_valid_o, ts_sec_o, ts_ns_o, ts_msg_type_o, ts_seq_id_o,
           ts_push_o, ts_ovf_cnt_o
  );

endinterface

// File: rtl/tsu_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is taken
// only when a pop frees an entry in the same cycle.
module tsu_sync_fifo #(
  parameter int WIDTH = 100,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             push_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tsu_rx_ptp_capture.sv
// Ingress snoop of the XGMII receive stream: timestamps each SOF, parses
// untagged PTPv2 headers and queues {sec, ns, messageType, sequenceId}.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | between frames, waiting for /S/
// ST_HDR      | walking aligned words 0..6 of a frame, checking the header
// ST_WAIT_END | frame recorded or rejected, waiting for terminate/error
module tsu_rx_ptp_capture
  import tsu_rx_ptp_capture_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned LANE4_ADJ_NS = 3,
  parameter int unsigned NS_PER_SEC   = 1000000000
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  input  logic                 rx_clk_en_i,
  input  logic                 dis_ptpv2_i,
  input  logic [63:0]          xge_rxd_i,
  input  logic [7:0]           xge_rxc_i,
  input  logic [47:0]          rtc_sec_i,
  input  logic [31:0]          rtc_ns_i,
  tsu_rx_ptp_capture_if.master ts
);

  cap_state_t  state_q, state_d;
  logic        lane4_q, lane4_d;
  logic [2:0]  w_q, w_d;
  logic [47:0] sec_q, sec_d;
  logic [31:0] ns_q, ns_d;
  logic [3:0]  msg_q, msg_d;
  logic [31:0] prev_d;
  logic [3:0]  prev_c;

  logic        sof0, sof4, sof;
  logic [63:0] al_d;
  logic [7:0]  al_c;
  logic        al_end;
  logic [32:0] ns_sum;
  logic [47:0] sec_sof;
  logic [31:0] ns_sof;
  logic        push_req;
  ts_rec_t     rec, head;
  logic        fifo_full, fifo_empty, push_ok;
  logic        ts_push_q;
  logic [7:0]  ovf_q;

  assign sof0 = xge_rxc_i[0] && (xge_rxd_i[7:0] == XGMII_START);
  assign sof4 = xge_rxc_i[4] && (xge_rxd_i[39:32] == XGMII_START) &&
                !lane_has({32'b0, xge_rxd_i[31:0]}, {4'b0, xge_rxc_i[3:0]}, XGMII_START);
  assign sof  = sof0 || sof4;

  // A lane-4 start is realigned by stitching the previous upper half in front.
  assign al_d   = lane4_q ? {xge_rxd_i[31:0], prev_d} : xge_rxd_i;
  assign al_c   = lane4_q ? {xge_rxc_i[3:0], prev_c}  : xge_rxc_i;
  assign al_end = lane_has(al_d, al_c, XGMII_TERM) || lane_has(al_d, al_c, XGMII_ERR);

  always_comb begin
    ns_sum  = {1'b0, rtc_ns_i} + (sof4 ? 33'(LANE4_ADJ_NS) : 33'd0);
    sec_sof = rtc_sec_i;
    ns_sof  = ns_sum[31:0];
    if (ns_sum >= 33'(NS_PER_SEC)) begin
      ns_sof  = 32'(ns_sum - 33'(NS_PER_SEC));
      sec_sof = rtc_sec_i + 48'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    lane4_d  = lane4_q;
    w_d      = w_q;
    sec_d    = sec_q;
    ns_d     = ns_q;
    msg_d    = msg_q;
    push_req = 1'b0;
    rec      = '{sec: sec_q, ns: ns_q, msg_type: msg_q, seq_id: {al_d[39:32], al_d[47:40]}};
    if (dis_ptpv2_i) begin
      state_d = ST_IDLE;
    end else if (sof) begin
      // w is the index of the aligned word presented in the coming cycle.
      state_d = ST_HDR;
      lane4_d = sof4;
      w_d     = sof4 ? 3'd0 : 3'd1;
      sec_d   = sec_sof;
      ns_d    = ns_sof;
    end else begin
      case (state_q)
        ST_HDR: begin
          if ((w_q != 3'd0) && al_end) begin
            state_d = ST_IDLE;
          end else begin
            w_d = w_q + 3'd1;
            if (w_q == ETYPE_W) begin
              if ({al_d[39:32], al_d[47:40]} == PTP_ETYPE && al_d[59:56] == PTP_VERSION)
                msg_d = al_d[51:48];
              else
                state_d = ST_WAIT_END;
            end
            if (w_q == SEQ_W) begin
              push_req = 1'b1;
              state_d  = ST_WAIT_END;
            end
          end
        end
        ST_WAIT_END: if (al_end) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q   <= ST_IDLE;
      lane4_q   <= 1'b0;
      w_q       <= '0;
      sec_q     <= '0;
      ns_q      <= '0;
      msg_q     <= '0;
      prev_d    <= '0;
      prev_c    <= '0;
      ts_push_q <= 1'b0;
      ovf_q     <= '0;
    end else if (rx_clk_en_i) begin
      state_q   <= state_d;
      lane4_q   <= lane4_d;
      w_q       <= w_d;
      sec_q     <= sec_d;
      ns_q      <= ns_d;
      msg_q     <= msg_d;
      prev_d    <= xge_rxd_i[63:32];
      prev_c    <= xge_rxc_i[7:4];
      ts_push_q <= push_ok;
      if (push_req && !push_ok && (ovf_q != 8'hFF)) ovf_q <= ovf_q + 8'd1;
    end
  end

  tsu_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (int'(FIFO_DEPTH))
  ) u_fifo (
    .clk     (rx_clk),
    .rst     (rx_rst),
    .push    (push_req && rx_clk_en_i),
    .pop     (ts.ts_rd_i && rx_clk_en_i),
    .din     (rec),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .push_ok (push_ok)
  );

  // Head fields read as zero while empty so nothing stale leaks out.
  assign ts.ts_valid_o    = !fifo_empty;
  assign ts.ts_sec_o      = fifo_empty ? '0 : head.sec;
  assign ts.ts_ns_o       = fifo_empty ? '0 : head.ns;
  assign ts.ts_msg_type_o = fifo_empty ? '0 : head.msg_type;
  assign ts.ts_seq_id_o   = fifo_empty ? '0 : head.seq_id;
  assign ts.ts_push_o     = ts_push_q;
  assign ts.ts_ovf_cnt_o  = ovf_q;

endmodule

// File: doc/tsu_rx_ptp_capture.md
Name: tsu_rx_ptp_capture

Overview:
- Receive-side ingress stage that sits directly upstream of the timestamp unit.
- Snoops the 64-bit XGMII receive stream and detects start-of-frame (/S/ in lane 0 or lane 4).
- Latches RTC time at SOF, parses untagged PTPv2 Ethernet frames (EtherType 0x88F7), and queues {seconds, ns, messageType, sequenceId} records in a 4-deep FIFO for the timestamp unit to pop.
- Observe-only; the data path is not modified.

Parameters:
- FIFO_DEPTH, 4, record FIFO entries (power of two, 2..16)
- LANE4_ADJ_NS, 3, ns added to the latched timestamp when /S/ is in lane 4
- NS_PER_SEC, 1000000000, nanosecond rollover value

Ports:
- rx_clk  in  1  receive clock; sole clock
- rx_rst  in  1  synchronous reset, active high
- rx_clk_en_i  in  1  qualifies every input cycle; state advances only when high
- dis_ptpv2_i  in  1  disable capture
- xge_rxd_i  in  64  XGMII data; lane n = bits[8n+7:8n]; lane 0 is first on the wire
- xge_rxc_i  in  8  XGMII control, one bit per lane
- rtc_sec_i  in  48  RTC seconds, already in the rx_clk domain
- rtc_ns_i  in  32  RTC nanoseconds (< NS_PER_SEC)
- ts_rd_i  in  1  pop FIFO head
- ts_valid_o  out  1  FIFO not empty
- ts_sec_o  out  48  head record seconds
- ts_ns_o  out  32  head record ns
- ts_msg_type_o  out  4  head record messageType
- ts_seq_id_o  out  16  head record sequenceId
- ts_push_o  out  1  one-cycle pulse per record written (interrupt source)
- ts_ovf_cnt_o  out  8  saturating count of records dropped because the FIFO was full

Behaviour:
- Reset (rx_rst high at a rising edge):
  - FIFO emptied; all outputs 0; FSM to IDLE; overflow counter 0.
  - A reset asserted mid-frame discards that frame.
- When rx_clk_en_i is low, no register changes; pops are ignored.
- SOF detection:
  - Lane 0: xge_rxc_i[0]=1 and byte 0xFB.
  - Lane 4: xge_rxc_i[4]=1 and byte 0xFB, with lanes 0..3 carrying no /S/.
- Timestamp at SOF:
  - sec_l = rtc_sec_i.
  - ns_l = rtc_ns_i + (lane4 ? LANE4_ADJ_NS : 0).
  - If ns_l >= NS_PER_SEC: ns_l -= NS_PER_SEC and sec_l += 1, wrapping at 2^48.
- Realignment:
  - A lane-0 SOF uses words as-is.
  - A lane-4 SOF uses aligned word = {cur[31:0], prev[63:32]}, which adds 1 cycle of latency.
  - Aligned word 0 holds /S/, preamble and SFD. Frame byte k sits in aligned word 1+k/8, lane k%8.
- FSM states: IDLE, HDR, WAIT_END.
  - IDLE -> HDR on SOF when dis_ptpv2_i=0. Word index w is cleared to 0.
  - HDR: w increments on each aligned word.
  - At w=2, all of the following must hold, otherwise go to WAIT_END (discard):
    - lane4 = 0x88 and lane5 = 0xF7;
    - lane7[3:0] = 2 (versionPTP);
    - messageType is taken from lane6[3:0].
  - At w=6: seqId = {lane4, lane5}. Push the record, then go to WAIT_END.
  - In HDR, any control lane carrying 0xFD (terminate) or 0xFE (error) in aligned words 1..6 aborts to IDLE with no push.
  - In HDR, a new SOF restarts capture for the new frame with a new timestamp; the old frame is discarded.
  - WAIT_END -> IDLE on 0xFD or 0xFE in any control lane. A SOF in WAIT_END behaves as in IDLE.
  - dis_ptpv2_i=1 forces IDLE; any in-progress frame is discarded, and records already queued remain.
- FIFO:
  - Push is registered; ts_push_o is high in the cycle after the w=6 word.
  - The output is first-word-fall-through: the head is valid while ts_valid_o=1.
  - Pop when empty is ignored.
  - Push when full (without a same-cycle pop): record dropped, ts_ovf_cnt_o += 1, saturating at 255, and ts_push_o stays low.
  - Simultaneous push and pop when full: both accepted, count unchanged.

Decomposition:
- Shared package (ptpv2_defines include):
  - XGMII codes START=0xFB, TERM=0xFD, ERR=0xFE;
  - PTP_ETYPE=16'h88F7 and PTP_VERSION=4'd2;
  - aligned-word offsets (ETYPE_W=2, SEQ_W=6);
  - record width 100 bits.
- One sub-module, tsu_sync_fifo: synchronous FWFT FIFO with full/empty and a same-cycle push/pop rule. The parser FSM and timestamp latch live in the top.

Test Plan:
- Lane-0 Sync frame (msgType 0, seqId 0x1234) with rtc = 5 s / 100 ns at SOF -> one ts_push_o pulse; head = {5, 100, 0, 0x1234}.
- Lane-4 Delay_Req (msgType 1, seqId 0xBEEF) with rtc_ns = 999_999_998 -> head sec+1, ns = 1, msgType 1, seqId 0xBEEF; push occurs one cycle later than the lane-0 equivalent.
- Non-PTP frame (EtherType 0x0800), then a PTP frame with version 1 -> no push, ts_valid_o stays 0.
- Terminate at aligned word 4, then back-to-back SOF mid-header -> first frame produces no record; only the second frame's record is pushed, with its own timestamp.
- Six PTP frames with no pops -> 4 records held, ts_ovf_cnt_o = 2. Then a push coinciding with a pop while full -> both accepted, count stays 2.
- rx_clk_en_i toggled 1-of-2 during a frame, dis_ptpv2_i asserted mid-header, and rx_rst asserted mid-frame -> identical record to the continuous case, no record, and FIFO empty with all outputs 0, respectively.
